ram_fifo_ctrl: RTL and testbench

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 91 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller backed by an external single-port RAM with 1-cycle read
// latency, plus one output register. Holds up to N_WORDS+1 words in total.
// Reads win the RAM port over writes, so a word moves to the output at most
// every other cycle.
module ram_fifo_ctrl #(
  parameter int  DATA_WIDTH = 16,
  parameter int  N_WORDS    = 32,
  localparam int ADDR_W     = $clog2(N_WORDS),
  localparam int CNT_W      = $clog2(N_WORDS + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty,
  output logic                  ram_we,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0]  DEPTH     = CNT_W'(N_WORDS);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  ram_count;
  logic              rd_pending;
  logic              rd_go, wr_go;

  // Fetch the next RAM word whenever the output register will be free by the
  // time the data returns. A write only gets the port when no read wants it.
  assign rd_go   = (ram_count != '0) && !rd_pending && (!m_valid || m_ready);
  assign s_ready = (ram_count != DEPTH) && !rd_go;
  // rst_n keeps the RAM write strobe quiet while reset is held, even though
  // s_ready reads 1 then.
  assign wr_go   = s_valid && s_ready && rst_n;

  assign ram_we      = wr_go;
  assign ram_re      = rd_go;
  assign ram_address = rd_go ? rd_ptr : wr_ptr;
  assign ram_data_in = s_data;

  assign count = ram_count + CNT_W'(rd_pending) + CNT_W'(m_valid);
  assign full  = (ram_count == DEPTH);
  assign empty = (count == '0);

  // Write pointer, wraps at N_WORDS-1 (depth need not be a power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_ptr <= '0;
    else if (wr_go) wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + ADDR_W'(1);
  end

  // Read pointer, same wrap rule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_ptr <= '0;
    else if (rd_go) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + ADDR_W'(1);
  end

  // Words resident in RAM; reads and writes never share a cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ram_count <= '0;
    else if (rd_go)  ram_count <= ram_count - CNT_W'(1);
    else if (wr_go)  ram_count <= ram_count + CNT_W'(1);
  end

  // Output register: load returning RAM data, otherwise drain on handshake.
  // A read in flight at reset is dropped because rd_pending clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pending <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      rd_pending <= rd_go;
      if (rd_pending) begin
        m_data  <= ram_data_out;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural 1-cycle-latency RAM.
// Inputs change 1 time unit after posedge; outputs are sampled 4 after.
module tb_ram_fifo_ctrl;
  localparam int DW = 16;
  localparam int NW = 32;
  localparam int AW = $clog2(NW);
  localparam int CW = $clog2(NW + 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic [CW-1:0] count;
  logic          full, empty, ram_we, ram_re;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out;

  logic [DW-1:0] mem [NW];
  int n_cmp = 0;
  int n_err = 0;
  int wr_wraps = 0;
  int rd_wraps = 0;
  logic [AW-1:0] last_wr = '0;
  logic [AW-1:0] last_rd = '0;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .N_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .full(full), .empty(empty),
    .ram_we(ram_we), .ram_re(ram_re), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // Attached single-port RAM, read data valid the cycle after ram_re
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
    if (ram_re) ram_data_out <= mem[ram_address];
  end

  // Track address wrap 31->0 on the write and read streams
  always @(negedge clk) begin
    if (ram_we) begin
      if (last_wr == AW'(NW - 1) && ram_address == '0) wr_wraps <= wr_wraps + 1;
      last_wr <= ram_address;
    end
    if (ram_re) begin
      if (last_rd == AW'(NW - 1) && ram_address == '0) rd_wraps <= rd_wraps + 1;
      last_rd <= ram_address;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word until accepted; starts and ends at posedge+1
  task automatic push(input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int c = 0; c < 50 && !ok; c++) begin
      #3;
      if (s_ready) ok = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    chk("push_ok", ok, 1);
  endtask

  // Pop n words expecting base, base+1, ...; starts and ends at posedge+1
  task automatic drain(input int base, input int n, input string tag);
    int got;
    got = 0;
    m_ready = 1'b1;
    for (int c = 0; c < 300 && got < n; c++) begin
      #3;
      if (m_valid) begin
        chk(tag, m_data, base + got);
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    chk({tag, "_cnt"}, got, n);
  endtask

  initial begin
    int acc;
    int w0, r0;

    // Reset state, with s_valid high to show the write strobe is held off
    s_valid = 1'b1;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_re", ram_re, 0);
    chk("rst_s_ready", s_ready, 1);
    s_valid = 1'b0;
    #7 rst_n = 1'b1;
    tick();

    // Single word: write c0, read c1, m_valid c3
    s_valid = 1'b1; s_data = 16'h1234; #3;
    chk("single_we", ram_we, 1);
    chk("single_we_addr", ram_address, 0);
    chk("single_re_c0", ram_re, 0);
    tick(); s_valid = 1'b0; #3;
    chk("single_re", ram_re, 1);
    chk("single_re_addr", ram_address, 0);
    chk("single_count_c1", count, 1);
    tick(); #3;
    chk("single_count_c2", count, 1);
    chk("single_mv_c2", m_valid, 0);
    tick(); m_ready = 1'b1; #3;
    chk("single_mv_c3", m_valid, 1);
    chk("single_data", m_data, 16'h1234);
    chk("single_count_c3", count, 1);
    tick(); m_ready = 1'b0; #3;
    chk("single_popped", m_valid, 0);
    chk("single_empty", empty, 1);
    chk("single_hold", m_data, 16'h1234);

    // Fill with m_ready low: 32 in RAM plus one in the output register
    tick();
    acc = 0;
    s_valid = 1'b1; s_data = 16'h0100;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (s_ready) acc++;
      tick();
      s_data = 16'h0100 + acc[15:0];
    end
    s_valid = 1'b0; #3;
    chk("fill_accepted", acc, 33);
    chk("fill_full", full, 1);
    chk("fill_s_ready", s_ready, 0);
    chk("fill_count", count, 33);
    chk("fill_head", m_data, 16'h0100);
    chk("fill_mv", m_valid, 1);
    tick();
    drain(32'h0100, 33, "fill_order");
    #3;
    chk("fill_empty", empty, 1);
    tick();

    // Collision: read wins over a simultaneous write
    for (int k = 0; k < 4; k++) push(16'hA000 + k[15:0]);
    s_valid = 1'b1; s_data = 16'hA004; m_ready = 1'b1; #3;
    chk("coll_count", count, 4);
    chk("coll_re", ram_re, 1);
    chk("coll_we", ram_we, 0);
    chk("coll_s_ready", s_ready, 0);
    chk("coll_head", m_data, 16'hA000);
    tick(); m_ready = 1'b0; #3;
    chk("coll_we_next", ram_we, 1);
    chk("coll_s_ready_next", s_ready, 1);
    tick(); s_valid = 1'b0;
    drain(32'hA001, 4, "coll_order");

    // Wrap: 40 words with random gaps on both sides
    w0 = wr_wraps; r0 = rd_wraps;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push(i[15:0]);
        end
      end
      begin
        int got;
        got = 0;
        for (int c = 0; c < 2000 && got < 40; c++) begin
          m_ready = ($urandom_range(0, 3) != 0);
          #3;
          if (m_valid && m_ready) begin
            chk("wrap_order", m_data, got);
            got++;
          end
          tick();
        end
        m_ready = 1'b0;
        chk("wrap_cnt", got, 40);
      end
    join
    chk("wrap_wr_addr", (wr_wraps > w0), 1);
    chk("wrap_rd_addr", (rd_wraps > r0), 1);

    // Reset while a read is in flight with 5 words left in RAM
    for (int k = 0; k < 7; k++) push(16'hC000 + k[15:0]);
    tick(); tick(); #3;
    chk("pend_count7", count, 7);
    tick(); m_ready = 1'b1; #3;
    chk("pend_re", ram_re, 1);
    tick(); m_ready = 1'b0; s_valid = 1'b1; s_data = 16'hDEAD; #3;
    chk("pend_count6", count, 6);
    rst_n = 1'b0; #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_re", ram_re, 0);
    chk("mid_rst_we", ram_we, 0);
    s_valid = 1'b0;
    tick(); #3;
    rst_n = 1'b1;
    tick(); #3;
    chk("post_rst_m_valid", m_valid, 0);
    chk("post_rst_count", count, 0);
    tick();
    push(16'hBEEF);
    push(16'hBEF0);
    drain(32'hBEEF, 2, "post_rst_order");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
